// File: rtl/image_y_sobel_edge.sv
// Sobel edge stage on the luma stream: two line buffers feed a 3x3 window,
// |Gx|+|Gy| is saturated to 8 bits and thresholded, with sync delay-matched.
module image_y_sobel_edge #(
    parameter logic [11:0] IMG_HDISP = 12'd640,
    parameter logic [11:0] IMG_VDISP = 12'd480
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        per_frame_vsync,
    input  logic        per_frame_href,
    input  logic        per_frame_clken,
    input  logic [7:0]  per_img_Y,
    input  logic [10:0] sobel_threshold,
    output logic        post_frame_vsync,
    output logic        post_frame_href,
    output logic        post_frame_clken,
    output logic [7:0]  post_img_mag,
    output logic        post_img_Bit
);
    localparam int STAGES = 4;
    localparam int AW     = (IMG_HDISP > 12'd1) ? $clog2(IMG_HDISP) : 1;

    logic [11:0]       col, row;
    logic [10:0]       thr_q;
    logic              vs_d, hr_d;
    logic              vs_rise, hr_fall, acc, in_rng, acc_in;
    logic [AW-1:0]     addr;
    logic [7:0]        lb1 [0:IMG_HDISP-1];
    logic [7:0]        lb2 [0:IMG_HDISP-1];
    logic [7:0]        lb1_rd, lb2_rd;
    logic [1:3][1:3][7:0] win;

    logic [STAGES-1:0] vs_pipe, hr_pipe, ck_pipe, vld_pipe;
    logic [2:0]        msk_pipe;
    logic [9:0]        gxp, gxn, gyp, gyn;
    logic signed [10:0] gx, gy;
    logic [10:0]       gx_abs, gy_abs, ax, ay, mag;
    logic [7:0]        mag_q;
    logic              bit_q;

    assign vs_rise = per_frame_vsync & ~vs_d;
    assign hr_fall = hr_d & ~per_frame_href;
    assign acc     = per_frame_href & per_frame_clken;
    assign in_rng  = (col < IMG_HDISP);
    assign acc_in  = acc & in_rng;
    assign addr    = col[AW-1:0];
    assign lb1_rd  = lb1[addr];
    assign lb2_rd  = lb2[addr];

    // vsync rise takes priority over the href-fall row advance
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col   <= '0;
            row   <= '0;
            thr_q <= '0;
            vs_d  <= 1'b0;
            hr_d  <= 1'b0;
        end else begin
            vs_d <= per_frame_vsync;
            hr_d <= per_frame_href;
            if (vs_rise) begin
                col   <= '0;
                row   <= '0;
                thr_q <= sobel_threshold;
            end else if (hr_fall) begin
                col <= '0;
                if (row != 12'hFFF) row <= row + 12'd1;
            end else if (acc_in) begin
                col <= col + 12'd1;
            end
        end
    end

    // Line buffers: read-before-write, lb1 holds the previous row, lb2 the one before
    always_ff @(posedge clk) begin
        if (acc_in) begin
            lb1[addr] <= per_img_Y;
            lb2[addr] <= lb1_rd;
        end
    end

    // S1: window shift, row 1 oldest, column 3 newest
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            win <= '0;
        end else if (acc_in) begin
            win[1] <= {win[1][2], win[1][3], lb2_rd};
            win[2] <= {win[2][2], win[2][3], lb1_rd};
            win[3] <= {win[3][2], win[3][3], per_img_Y};
        end
    end

    // Sync delay lines and border mask; lines past IMG_VDISP are masked too
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vs_pipe  <= '0;
            hr_pipe  <= '0;
            ck_pipe  <= '0;
            vld_pipe <= '0;
            msk_pipe <= '0;
        end else begin
            vs_pipe  <= {vs_pipe[STAGES-2:0], per_frame_vsync};
            hr_pipe  <= {hr_pipe[STAGES-2:0], per_frame_href};
            ck_pipe  <= {ck_pipe[STAGES-2:0], per_frame_clken};
            vld_pipe <= {vld_pipe[STAGES-2:0], acc};
            msk_pipe[2:1] <= msk_pipe[1:0];
            if (acc)
                msk_pipe[0] <= ~in_rng | (row < 12'd2) | (col < 12'd2) | (row >= IMG_VDISP);
        end
    end

    // S2: partial sums
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gxp <= '0;
            gxn <= '0;
            gyp <= '0;
            gyn <= '0;
        end else begin
            gxp <= 10'(win[1][3]) + (10'(win[2][3]) << 1) + 10'(win[3][3]);
            gxn <= 10'(win[1][1]) + (10'(win[2][1]) << 1) + 10'(win[3][1]);
            gyp <= 10'(win[1][1]) + (10'(win[1][2]) << 1) + 10'(win[1][3]);
            gyn <= 10'(win[3][1]) + (10'(win[3][2]) << 1) + 10'(win[3][3]);
        end
    end

    // S3: signed gradients and magnitudes
    assign gx = $signed({1'b0, gxp}) - $signed({1'b0, gxn});
    assign gy = $signed({1'b0, gyp}) - $signed({1'b0, gyn});

    always_comb begin
        gx_abs = gx[10] ? 11'(-gx) : 11'(gx);
        gy_abs = gy[10] ? 11'(-gy) : 11'(gy);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ax <= '0;
            ay <= '0;
        end else begin
            ax <= gx_abs;
            ay <= gy_abs;
        end
    end

    // S4: sum, saturate, compare; hold through clken gaps, zero outside href
    assign mag = ax + ay;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mag_q <= '0;
            bit_q <= 1'b0;
        end else if (!hr_pipe[2]) begin
            mag_q <= '0;
            bit_q <= 1'b0;
        end else if (vld_pipe[2]) begin
            mag_q <= msk_pipe[2] ? 8'd0 : ((mag > 11'd255) ? 8'hFF : mag[7:0]);
            bit_q <= ~msk_pipe[2] & (mag > thr_q);
        end
    end

    assign post_frame_vsync = vs_pipe[STAGES-1];
    assign post_frame_href  = hr_pipe[STAGES-1];
    assign post_frame_clken = ck_pipe[STAGES-1];
    assign post_img_mag     = mag_q;
    assign post_img_Bit     = bit_q;

endmodule

// File: tb/tb_image_y_sobel_edge.sv
// Directed bench for image_y_sobel_edge on an 8x6 frame: flat, steps,
// threshold boundary, clken gaps and mid-frame reset.
module tb_image_y_sobel_edge;
    localparam int W = 8;
    localparam int H = 6;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        vs, hr, ck;
    logic [7:0]  y;
    logic [10:0] thr;
    logic        pv, ph, pc, pb;
    logic [7:0]  pm;

    int checks = 0;
    int errors = 0;
    bit sync_chk = 1'b0;
    logic [2:0] hist [0:3];
    logic [7:0] cap_mag [$];
    logic       cap_bit [$];

    always #5 clk = ~clk;

    image_y_sobel_edge #(.IMG_HDISP(12'd8), .IMG_VDISP(12'd6)) dut (
        .clk(clk), .rst_n(rst_n),
        .per_frame_vsync(vs), .per_frame_href(hr), .per_frame_clken(ck),
        .per_img_Y(y), .sobel_threshold(thr),
        .post_frame_vsync(pv), .post_frame_href(ph), .post_frame_clken(pc),
        .post_img_mag(pm), .post_img_Bit(pb)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Sample outputs at the falling edge, then drive the next inputs
    task automatic tick(input logic v, input logic h, input logic c, input logic [7:0] yy);
        @(negedge clk);
        if (!ph) begin
            chk("idle_mag", 16'(pm), 16'd0);
            chk("idle_bit", 16'(pb), 16'd0);
        end else if (pc) begin
            cap_mag.push_back(pm);
            cap_bit.push_back(pb);
        end
        if (sync_chk) chk("sync_delay4", 16'({pv, ph, pc}), 16'(hist[3]));
        hist[3] = hist[2];
        hist[2] = hist[1];
        hist[1] = hist[0];
        hist[0] = {v, h, c};
        vs = v; hr = h; ck = c; y = yy;
    endtask

    function automatic logic [7:0] pix(input int pat, input int r, input int c);
        case (pat)
            0: return 8'd100;
            1: return (c >= 4) ? 8'd255 : 8'd0;
            2: return (r >= 3) ? 8'd200 : 8'd0;
            3: return (c >= 4) ? 8'd16 : 8'd0;
            default: return 8'd0;
        endcase
    endfunction

    // Hand-derived: vstep edge at c=4,5 (1020 / 64 raw), hstep at r=3,4 (800 raw)
    function automatic int exp_mag(input int pat, input int r, input int c);
        if (r < 2 || c < 2) return 0;
        case (pat)
            1: return (c == 4 || c == 5) ? 255 : 0;
            2: return (r == 3 || r == 4) ? 255 : 0;
            3: return (c == 4 || c == 5) ? 64 : 0;
            default: return 0;
        endcase
    endfunction

    function automatic int exp_bit(input int pat, input int r, input int c, input int t);
        if (exp_mag(pat, r, c) == 0) return 0;
        if (pat == 3) return (64 > t) ? 1 : 0;
        return 1;
    endfunction

    task automatic frame_head();
        repeat (2) tick(1'b0, 1'b0, 1'b0, 8'd0);
        repeat (3) tick(1'b1, 1'b0, 1'b0, 8'd0);
    endtask

    task automatic send_row(input int pat, input int r, input bit gaps);
        for (int c = 0; c < W; c++) begin
            if (gaps) tick(1'b1, 1'b1, 1'b0, 8'd0);
            tick(1'b1, 1'b1, 1'b1, pix(pat, r, c));
        end
    endtask

    task automatic run_frame(input int pat, input bit gaps, input logic [10:0] mid_thr);
        cap_mag.delete();
        cap_bit.delete();
        frame_head();
        for (int r = 0; r < H; r++) begin
            if (r == 3) thr = mid_thr;
            send_row(pat, r, gaps);
            repeat (3) tick(1'b1, 1'b0, 1'b0, 8'd0);
        end
        repeat (6) tick(1'b0, 1'b0, 1'b0, 8'd0);
    endtask

    task automatic check_frame(input int pat, input int t, input string tag);
        chk({tag, "_count"}, 16'(cap_mag.size()), 16'(W * H));
        if (cap_mag.size() == W * H) begin
            for (int r = 0; r < H; r++) begin
                for (int c = 0; c < W; c++) begin
                    chk($sformatf("%s_mag_r%0dc%0d", tag, r, c), 16'(cap_mag[r*W+c]), 16'(exp_mag(pat, r, c)));
                    chk($sformatf("%s_bit_r%0dc%0d", tag, r, c), 16'(cap_bit[r*W+c]), 16'(exp_bit(pat, r, c, t)));
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        vs = 1'b0; hr = 1'b0; ck = 1'b0; y = 8'd0; thr = 11'd10;
        for (int i = 0; i < 4; i++) hist[i] = 3'b000;

        repeat (3) tick(1'b0, 1'b0, 1'b0, 8'd0);
        chk("rst_vsync", 16'(pv), 16'd0);
        chk("rst_href",  16'(ph), 16'd0);
        chk("rst_clken", 16'(pc), 16'd0);
        chk("rst_mag",   16'(pm), 16'd0);
        chk("rst_bit",   16'(pb), 16'd0);
        rst_n = 1'b1;
        repeat (2) tick(1'b0, 1'b0, 1'b0, 8'd0);

        // Flat frame, sync lines checked against a 4-deep input history
        thr = 11'd10;
        sync_chk = 1'b1;
        run_frame(0, 1'b0, 11'd10);
        sync_chk = 1'b0;
        check_frame(0, 10, "flat");

        thr = 11'd100;
        run_frame(1, 1'b0, 11'd100);
        check_frame(1, 100, "vstep");

        run_frame(2, 1'b0, 11'd100);
        check_frame(2, 100, "hstep");

        // Threshold boundary: raw 64 vs 64 is not an edge; mid-frame change to 63 deferred
        thr = 11'd64;
        run_frame(3, 1'b0, 11'd63);
        check_frame(3, 64, "thr64");
        run_frame(3, 1'b0, 11'd63);
        check_frame(3, 63, "thr63");

        thr = 11'd100;
        run_frame(1, 1'b1, 11'd100);
        check_frame(1, 100, "vgap");

        // Mid-frame reset while an edge pixel is in flight
        frame_head();
        for (int r = 0; r < 5; r++) begin
            send_row(1, r, 1'b0);
            if (r < 4) repeat (3) tick(1'b1, 1'b0, 1'b0, 8'd0);
        end
        rst_n = 1'b0;
        tick(1'b1, 1'b0, 1'b0, 8'd0);
        chk("midrst_vsync", 16'(pv), 16'd0);
        chk("midrst_href",  16'(ph), 16'd0);
        chk("midrst_clken", 16'(pc), 16'd0);
        chk("midrst_mag",   16'(pm), 16'd0);
        chk("midrst_bit",   16'(pb), 16'd0);
        repeat (2) tick(1'b1, 1'b0, 1'b0, 8'd0);
        rst_n = 1'b1;
        repeat (3) tick(1'b1, 1'b0, 1'b0, 8'd0);
        repeat (4) tick(1'b0, 1'b0, 1'b0, 8'd0);
        run_frame(1, 1'b0, 11'd100);
        check_frame(1, 100, "postrst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/image_y_sobel_edge.md
Name: image_y_sobel_edge

Overview:
- Sobel edge stage that consumes the 8-bit luma (Y) stream produced by the RGB888-to-YCbCr444 converter in the sobel_edge video path.
- Keeps two internal line buffers and builds a 3x3 window, then computes |Gx|+|Gy|.
- Outputs a saturated 8-bit gradient magnitude and a 1-bit thresholded edge flag.
- vsync/href/clken are delay-matched to the data.

Parameters:
IMG_HDISP, 12'd640, active pixels per line (line-buffer depth)
IMG_VDISP, 12'd480, active lines per frame

Ports:
clk  input  1  video pixel clock
rst_n  input  1  reset, synchronous, active-low
per_frame_vsync  input  1  frame valid, active high
per_frame_href  input  1  line valid, active high
per_frame_clken  input  1  pixel enable
per_img_Y  input  8  luma pixel
sobel_threshold  input  11  edge threshold, sampled per frame
post_frame_vsync  output  1  vsync delayed 4 clk
post_frame_href  output  1  href delayed 4 clk
post_frame_clken  output  1  clken delayed 4 clk
post_img_mag  output  8  gradient magnitude, saturated
post_img_Bit  output  1  edge flag

Behaviour:
- One clock (clk). Reset is synchronous and active-low (rst_n); every register updates only on posedge clk.
- Reset: all counters, window registers, pipeline registers and sync delay lines go to 0. All outputs read 0. Line-buffer RAM contents are don't-care.
- Accept: a pixel is accepted on a cycle with href=1 and clken=1. Nothing shifts or counts on other cycles.
- Counters:
  - col (12 b) increments per accepted pixel and saturates at IMG_HDISP.
  - Pixels with col>=IMG_HDISP are not written to the buffers and produce mag=0 and Bit=0.
  - href falling edge: col<=0, row++. row saturates at 4095.
  - vsync rising edge: row<=0, col<=0, threshold register<=sobel_threshold.
- Window: for an accepted pixel at (r,c), P[i][j] covers rows r-2..r (i=1 is oldest) and cols c-2..c (j=1 is leftmost).
  - Line buffer 1 holds row r-1; line buffer 2 holds row r-2.
  - Read-before-write at address col.
  - Each row feeds a 3-deep column shift register.
- Border: if r<2 or c<2, force mag=0 and Bit=0, even though the window contents are stale.
- Arithmetic:
  - Gx = (P13+2P23+P33) - (P11+2P21+P31)
  - Gy = (P11+2P12+P13) - (P31+2P32+P33)
  - Partial sums are unsigned 10 b. Gx and Gy are signed 11 b.
  - mag = |Gx|+|Gy| is unsigned 11 b, maximum 2040.
  - post_img_mag = (mag>255) ? 255 : mag[7:0].
  - post_img_Bit = (mag > threshold register), i.e. strictly greater.
- Pipeline, fixed 4 clk from accept to output:
  - S1: window/line-buffer update.
  - S2: partial sums.
  - S3: Gx, Gy and absolute values.
  - S4: sum, saturate, compare, border mask.
- vsync, href and clken each pass through a 4-stage shift register.
- Data outputs read 0 whenever post_frame_href=0. During href with post clken=0, they hold their last value.
- clken gaps: the output pixel sequence is identical to the gap-free case. Only its timing follows the delayed clken.
- Threshold: a change to sobel_threshold mid-frame has no effect until the next vsync rising edge.
- Reset mid-frame: outputs go to 0 on the reset cycle. Output resumes correctly only after the next vsync rising edge. Pixels before that edge may be garbage but must not lock up the counters.
- Simultaneous vsync rise and href fall: vsync wins, so row=0 and col=0.

Test Plan:
1. Reset: rst_n=0 for 3 clk in mid-frame -> all post_* = 0 on the cycle after the first low sample. The next full frame after vsync matches the golden model.
2. Flat frame, IMG_HDISP=8, IMG_VDISP=6, Y=100 everywhere, threshold=10 -> every mag=0 and Bit=0. post_vsync/href/clken equal the inputs delayed exactly 4 clk.
3. Vertical step, 8x6: cols 0-3 Y=0, cols 4-7 Y=255, threshold=100 -> for rows>=2, c=4 and c=5 give mag=255 (raw 1020) and Bit=1. Cols 2, 3, 6 and 7 give 0. Rows 0-1 and cols 0-1 give 0.
4. Horizontal step, 8x6: rows 0-2 Y=0, rows 3-5 Y=200 -> for cols>=2, rows 3 and 4 give mag=255 (raw 800) and Bit=1. Row 2 and row 5 give 0.
5. Threshold edge: vertical step of 16 gives raw mag=64. With threshold=64 -> Bit=0 and mag=64. Next frame, with threshold changed to 63 mid-frame -> Bit=1 only from that frame onward.
6. clken=0 every other cycle within href, using the pattern from scenario 3 -> the post_img_mag/Bit sequence sampled on post_clken is identical to scenario 3.
